// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage hazard controller bundle: ID instruction fields and pipeline events in,
// stall/flush controls and status out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // id_valid qualifies the ID fields in the same cycle. There is no ready signal:
  // the controller responds combinationally through freeze/bubble/flush, and the
  // pipeline is expected to honour them on the next clock edge.
  logic             id_valid;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             two_src;
  logic [3:0]       id_dest;
  logic             id_wb_en;
  logic             id_mem_read;
  logic             branch_taken;
  logic             mem_wait;
  logic             hazard;
  logic             freeze_pc;
  logic             freeze_ifid;
  logic             bubble_idex;
  logic             flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, src1, src2, two_src, id_dest, id_wb_en, id_mem_read,
           branch_taken, mem_wait,
    input  hazard, freeze_pc, freeze_ifid, bubble_idex, flush, state, stall_cnt
  );

  modport slave (
    input  id_valid, src1, src2, two_src, id_dest, id_wb_en, id_mem_read,
           branch_taken, mem_wait,
    output hazard, freeze_pc, freeze_ifid, bubble_idex, flush, state, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer beside ID: tracks EXE/MEM destinations itself and arbitrates
// memory wait > taken branch > data hazard, with a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipeline_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_MWAIT = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_exe_v;
  logic [3:0]       r_exe_dest;
  logic             r_exe_ld;
  logic             r_mem_v;
  logic [3:0]       r_mem_dest;
  state_t           r_state;
  logic [CNT_W-1:0] r_stall_cnt;

  logic   w_m1;
  logic   w_m2;
  logic   w_hazard;
  logic   w_issue;
  logic   w_freeze;
  logic   w_bubble;
  logic   w_flush;
  state_t w_next;

  always_comb begin
    w_m1 = (r_exe_v && (bus.src1 == r_exe_dest)) || (r_mem_v && (bus.src1 == r_mem_dest));
    w_m2 = (r_exe_v && (bus.src2 == r_exe_dest)) || (r_mem_v && (bus.src2 == r_mem_dest));
    // With forwarding only a load sitting in EXE cannot be bypassed in time.
    if (FWD_EN != 0) begin
      w_hazard = bus.id_valid && r_exe_v && r_exe_ld &&
                 ((bus.src1 == r_exe_dest) || (bus.two_src && (bus.src2 == r_exe_dest)));
    end else begin
      w_hazard = bus.id_valid && (w_m1 || (bus.two_src && w_m2));
    end
  end

  always_comb begin
    w_freeze = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    w_next   = ST_RUN;
    if (bus.mem_wait) begin
      w_freeze = 1'b1;
      w_next   = ST_MWAIT;
    end else if (bus.branch_taken) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
      w_next   = ST_FLUSH;
    end else if (w_hazard) begin
      w_freeze = 1'b1;
      w_bubble = 1'b1;
      w_next   = ST_HAZ;
    end
  end

  assign w_issue = bus.id_valid && !w_hazard && !bus.branch_taken;

  assign bus.hazard      = rst_n && w_hazard;
  assign bus.freeze_pc   = rst_n && w_freeze;
  assign bus.freeze_ifid = rst_n && w_freeze;
  assign bus.bubble_idex = rst_n && w_bubble;
  assign bus.flush       = rst_n && w_flush;
  assign bus.state       = r_state;
  assign bus.stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exe_v     <= 1'b0;
      r_exe_dest  <= 4'd0;
      r_exe_ld    <= 1'b0;
      r_mem_v     <= 1'b0;
      r_mem_dest  <= 4'd0;
      r_state     <= ST_RUN;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_freeze && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      // Slots age only when the whole pipeline moves.
      if (!bus.mem_wait) begin
        r_mem_v    <= r_exe_v;
        r_mem_dest <= r_exe_dest;
        r_exe_v    <= w_issue && bus.id_wb_en;
        r_exe_dest <= w_issue ? bus.id_dest : 4'd0;
        r_exe_ld   <= w_issue && bus.id_mem_read;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench: a non-forwarding (16-bit counter) and a forwarding (4-bit counter) instance
// share one stimulus stream and are checked every cycle against an in-flight-list model.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] src1 = '0;
  logic [3:0] src2 = '0;
  logic       two_src = 1'b0;
  logic [3:0] id_dest = '0;
  logic       id_wb_en = 1'b0;
  logic       id_mem_read = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_wait = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) if0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  if1 ();

  assign if0.id_valid = id_valid;      assign if1.id_valid = id_valid;
  assign if0.src1 = src1;              assign if1.src1 = src1;
  assign if0.src2 = src2;              assign if1.src2 = src2;
  assign if0.two_src = two_src;        assign if1.two_src = two_src;
  assign if0.id_dest = id_dest;        assign if1.id_dest = id_dest;
  assign if0.id_wb_en = id_wb_en;      assign if1.id_wb_en = id_wb_en;
  assign if0.id_mem_read = id_mem_read; assign if1.id_mem_read = id_mem_read;
  assign if0.branch_taken = branch_taken; assign if1.branch_taken = branch_taken;
  assign if0.mem_wait = mem_wait;      assign if1.mem_wait = mem_wait;

  pipeline_hazard_ctrl #(.FWD_EN(0), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pipeline_hazard_ctrl #(.FWD_EN(1), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of in-flight writers, youngest (EXE) first, oldest (MEM) last.
  typedef struct packed {
    logic       v;
    logic [3:0] dest;
    logic       ld;
  } slot_t;

  slot_t q0[$];
  slot_t q1[$];
  slot_t qtmp[$];
  int    st_m[2];
  int    cnt_m[2];
  int    cnt_max[2] = '{65535, 15};

  task automatic model_reset();
    slot_t e;
    e = '0;
    q0 = {};
    q1 = {};
    q0.push_back(e); q0.push_back(e);
    q1.push_back(e); q1.push_back(e);
    for (int k = 0; k < 2; k++) begin
      st_m[k]  = 0;
      cnt_m[k] = 0;
    end
  endtask

  task automatic eval_dut(input int k, input bit fwd, input slot_t q[$],
                          input logic [6:0] act, input logic [15:0] act_cnt,
                          output slot_t qn[$]);
    bit         hz;
    bit         iss;
    int         d;
    logic [6:0] exp;
    slot_t      ns;
    hz = 1'b0;
    if (id_valid) begin
      for (int i = 0; i < q.size(); i++) begin
        if (!(fwd && i > 0) && q[i].v && (!fwd || q[i].ld) &&
            ((src1 == q[i].dest) || (two_src && (src2 == q[i].dest))))
          hz = 1'b1;
      end
    end
    d = mem_wait ? 2 : (branch_taken ? 3 : (hz ? 1 : 0));
    exp = {hz, (d == 1 || d == 2), (d == 1 || d == 2), (d == 1 || d == 3), (d == 3),
           2'(st_m[k])};
    check($sformatf("dut%0d ctrl {hz,fpc,fif,bub,fl,st}", k), {25'd0, act}, {25'd0, exp});
    check($sformatf("dut%0d stall_cnt", k), {16'd0, act_cnt}, 32'(cnt_m[k]));
    qn = q;
    if (!mem_wait) begin
      iss = id_valid && !hz && !branch_taken;
      ns.v    = iss && id_wb_en;
      ns.dest = id_dest;
      ns.ld   = iss && id_mem_read;
      qn.push_front(ns);
      void'(qn.pop_back());
    end
    if ((d == 1 || d == 2) && cnt_m[k] < cnt_max[k]) cnt_m[k]++;
    st_m[k] = d;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst dut0 ctrl", {25'd0, if0.hazard, if0.freeze_pc, if0.freeze_ifid,
            if0.bubble_idex, if0.flush, if0.state}, 32'd0);
      check("rst dut1 ctrl", {25'd0, if1.hazard, if1.freeze_pc, if1.freeze_ifid,
            if1.bubble_idex, if1.flush, if1.state}, 32'd0);
      check("rst stall_cnt", {12'd0, if1.stall_cnt, if0.stall_cnt}, 32'd0);
      model_reset();
    end else begin
      eval_dut(0, 1'b0, q0, {if0.hazard, if0.freeze_pc, if0.freeze_ifid, if0.bubble_idex,
               if0.flush, if0.state}, if0.stall_cnt, qtmp);
      q0 = qtmp;
      eval_dut(1, 1'b1, q1, {if1.hazard, if1.freeze_pc, if1.freeze_ifid, if1.bubble_idex,
               if1.flush, if1.state}, {12'd0, if1.stall_cnt}, qtmp);
      q1 = qtmp;
    end
  end

  task automatic set_in(input bit v, input bit [3:0] s1, input bit [3:0] s2, input bit two,
                        input bit [3:0] d, input bit wb, input bit ld, input bit br,
                        input bit mw);
    id_valid = v; src1 = s1; src2 = s2; two_src = two; id_dest = d;
    id_wb_en = wb; id_mem_read = ld; branch_taken = br; mem_wait = mw;
  endtask

  task automatic drive(input bit v, input bit [3:0] s1, input bit [3:0] s2, input bit two,
                       input bit [3:0] d, input bit wb, input bit ld, input bit br,
                       input bit mw);
    @(posedge clk);
    #1;
    set_in(v, s1, s2, two, d, wb, ld, br, mw);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Independent stream: no stalls at all.
    drive(1, 4, 5, 1, 1, 1, 0, 0, 0);
    peek(); check("indep hazard0", 32'(if0.hazard), 32'd0);
    drive(1, 4, 5, 1, 2, 1, 0, 0, 0);
    drive(1, 4, 5, 1, 3, 1, 0, 0, 0);
    idle();
    peek();
    check("indep state0", 32'(if0.state), 32'd0);
    check("indep stall0", 32'(if0.stall_cnt), 32'd0);

    // Non-forwarding RAW on EXE: two stall cycles; non-load is free with forwarding.
    do_reset();
    drive(1, 4, 5, 0, 3, 1, 0, 0, 0);
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0);
    peek();
    check("raw c1 hazard0", 32'(if0.hazard), 32'd1);
    check("raw c1 bubble0", 32'(if0.bubble_idex), 32'd1);
    check("raw c1 hazard1", 32'(if1.hazard), 32'd0);
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0);
    peek();
    check("raw c2 hazard0", 32'(if0.hazard), 32'd1);
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0);
    peek();
    check("raw c3 hazard0", 32'(if0.hazard), 32'd0);
    idle();
    peek();
    check("raw stall0", 32'(if0.stall_cnt), 32'd2);
    check("raw stall1", 32'(if1.stall_cnt), 32'd0);

    // Load-use via src2: one stall with forwarding.
    do_reset();
    drive(1, 0, 0, 0, 5, 1, 1, 0, 0);
    drive(1, 7, 5, 1, 8, 1, 0, 0, 0);
    drive(1, 7, 5, 1, 8, 1, 0, 0, 0);
    drive(1, 7, 5, 1, 8, 1, 0, 0, 0);
    idle();
    peek();
    check("ld-use stall1", 32'(if1.stall_cnt), 32'd1);
    check("ld-use stall0", 32'(if0.stall_cnt), 32'd2);

    // mem_wait inside a hazard stall extends it without ageing the slots.
    do_reset();
    drive(1, 4, 5, 0, 3, 1, 0, 0, 0);
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0);
    repeat (3) drive(1, 3, 0, 0, 6, 1, 0, 0, 1);
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0);
    peek();
    check("mw resume hazard0", 32'(if0.hazard), 32'd1);
    check("mw resume state0", 32'(if0.state), 32'd2);
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0);
    idle();
    peek();
    check("mw stall0", 32'(if0.stall_cnt), 32'd5);
    check("mw stall1", 32'(if1.stall_cnt), 32'd3);

    // Taken branch overrides a pending hazard.
    do_reset();
    drive(1, 4, 5, 0, 3, 1, 0, 0, 0);
    drive(1, 3, 0, 0, 6, 1, 0, 1, 0);
    peek();
    check("br flush0", 32'(if0.flush), 32'd1);
    check("br bubble0", 32'(if0.bubble_idex), 32'd1);
    check("br freeze0", 32'(if0.freeze_pc), 32'd0);
    check("br hazard0", 32'(if0.hazard), 32'd1);
    drive(1, 6, 0, 0, 7, 1, 0, 0, 0);
    peek();
    check("br next state0", 32'(if0.state), 32'd3);

    // Reset asserted in the middle of a stall.
    do_reset();
    drive(1, 4, 5, 0, 3, 1, 0, 0, 0);
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst hazard0", 32'(if0.hazard), 32'd0);
    check("midrst freeze0", 32'(if0.freeze_pc), 32'd0);
    check("midrst stall0", 32'(if0.stall_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    peek();
    check("post-rst state0", 32'(if0.state), 32'd0);
    check("post-rst stall0", 32'(if0.stall_cnt), 32'd0);
    drive(1, 3, 0, 0, 6, 1, 0, 0, 0);
    peek();
    check("post-rst empty slots", 32'(if0.hazard), 32'd0);

    // Randomised traffic on a small register file to provoke dependencies.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 4) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 5) == 0);
      end
    end

    idle();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
